// File: rtl/cc3_sys_pkg.sv
// Shared types and constants for the CC3 system controller.
package cc3_sys_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

    typedef enum logic [1:0] {
        INT  = 2'd0,
        EXT  = 2'd1,
        NONE = 2'd2
    } region_t;

    localparam logic [7:0] UNMAPPED_RDATA = 8'hFF;
    localparam int         SYNC_STAGES    = 2;

endpackage

// File: rtl/cc3_sync2.sv
// Two-flop synchroniser with an asynchronous reset to a selectable level.
module cc3_sync2
    import cc3_sys_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk32_i,
    input  logic reset_n_i,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sr;

    always_ff @(posedge clk32_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sr <= {SYNC_STAGES{RST_VAL}};
        end else begin
            sr <= {sr[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sr[SYNC_STAGES-1];

endmodule

// File: rtl/cc3_sys_ctrl.sv
// CC3 system controller: CPU reset stretcher, interrupt synchronisers, bus decode,
// internal RAM and wait-stated external memory. Optional macro: CC3_WRITE_PROTECT_EN.
module cc3_sys_ctrl
    import cc3_sys_pkg::*;
#(
    parameter int                RESET_CYCLES = 15,
    parameter int                INT_AW       = 11,
    parameter logic [15:0]       INT_BASE     = 16'hF800,
    parameter string             INT_INIT     = "",
    parameter int                EXT_AW       = 15,
    parameter logic [15:0]       EXT_BASE     = 16'h0000,
    parameter int                EXT_WAIT     = 2,
    parameter logic [INT_AW-1:0] WP_OFFSET    = 'h400
) (
    input  logic              clk32_i,
    input  logic              reset_n_i,
    output logic              cpu_reset_n_o,
    output logic              cpu_clken_o,
    input  logic              cpu_oe_i,
    input  logic              cpu_we_i,
    input  logic [15:0]       cpu_addr_i,
    input  logic [7:0]        cpu_wdata_i,
    output logic [7:0]        cpu_rdata_o,
    input  logic              nmi_n_i,
    input  logic              irq_n_i,
    input  logic              firq_n_i,
    output logic              cpu_nmi_n_o,
    output logic              cpu_irq_n_o,
    output logic              cpu_firq_n_o,
    output logic [EXT_AW-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    input  logic [7:0]        mem_rdata_i,
    output logic              mem_oe_n_o,
    output logic              mem_we_n_o,
    output logic              wp_err_o,
    output logic [1:0]        dbg_state_o
);

`ifdef CC3_WRITE_PROTECT_EN
    localparam bit WP_EN = 1'b1;
`else
    localparam bit WP_EN = 1'b0;
`endif

    logic       rst_sync_n;
    logic [7:0] rst_cnt;
    logic       nmi_s, irq_s, firq_s;

    cc3_sync2 #(.RST_VAL(1'b0)) u_rst_sync  (.clk32_i(clk32_i), .reset_n_i(reset_n_i), .d(1'b1),     .q(rst_sync_n));
    cc3_sync2 #(.RST_VAL(1'b1)) u_nmi_sync  (.clk32_i(clk32_i), .reset_n_i(reset_n_i), .d(nmi_n_i),  .q(nmi_s));
    cc3_sync2 #(.RST_VAL(1'b1)) u_irq_sync  (.clk32_i(clk32_i), .reset_n_i(reset_n_i), .d(irq_n_i),  .q(irq_s));
    cc3_sync2 #(.RST_VAL(1'b1)) u_firq_sync (.clk32_i(clk32_i), .reset_n_i(reset_n_i), .d(firq_n_i), .q(firq_s));

    always_ff @(posedge clk32_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rst_cnt       <= 8'd0;
            cpu_reset_n_o <= 1'b0;
        end else if (rst_sync_n && !cpu_reset_n_o) begin
            rst_cnt <= rst_cnt + 8'd1;
            if (rst_cnt == 8'(RESET_CYCLES - 1)) cpu_reset_n_o <= 1'b1;
        end
    end

    assign cpu_nmi_n_o  = nmi_s  | ~cpu_reset_n_o;
    assign cpu_irq_n_o  = irq_s  | ~cpu_reset_n_o;
    assign cpu_firq_n_o = firq_s | ~cpu_reset_n_o;

    fsm_state_t        state;
    region_t           region;
    logic [3:0]        wait_cnt;
    logic [INT_AW-1:0] int_off;
    logic              bus_rd, bus_wr, int_wr, wp_block, wp_err;
    logic [7:0]        ram [0:(1<<INT_AW)-1];

    always_comb begin
        region = NONE;
        if (cpu_addr_i[15:INT_AW] == INT_BASE[15:INT_AW])      region = INT;
        else if (cpu_addr_i[15:EXT_AW] == EXT_BASE[15:EXT_AW]) region = EXT;
    end

    // Handshake: the CPU presents one strobe (we wins over oe) with address/data and
    // treats the access as complete on the first cycle it sees cpu_clken_o high again.
    // Only IDLE accepts a strobe, so a strobe still held while in DONE is not restarted.
    assign int_off  = cpu_addr_i[INT_AW-1:0];
    assign bus_wr   = cpu_reset_n_o & cpu_we_i;
    assign bus_rd   = cpu_reset_n_o & cpu_oe_i & ~cpu_we_i;
    assign int_wr   = (state == IDLE) & bus_wr & (region == INT);
    assign wp_block = WP_EN & (int_off >= WP_OFFSET);

    // Zero image only; the array itself has no reset so it maps onto block RAM.
    initial begin
        for (int i = 0; i < (1 << INT_AW); i++) ram[i] = 8'h00;
    end

    always_ff @(posedge clk32_i) begin
        if (int_wr && !wp_block) ram[int_off] <= cpu_wdata_i;
    end

    always_ff @(posedge clk32_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state       <= IDLE;
            wait_cnt    <= 4'd0;
            cpu_clken_o <= 1'b1;
            cpu_rdata_o <= 8'h00;
            mem_addr_o  <= '0;
            mem_wdata_o <= 8'h00;
            mem_oe_n_o  <= 1'b1;
            mem_we_n_o  <= 1'b1;
            wp_err      <= 1'b0;
        end else begin
            wp_err <= int_wr & wp_block;
            case (state)
                IDLE: begin
                    if (bus_rd || bus_wr) begin
                        case (region)
                            INT: if (bus_rd) cpu_rdata_o <= ram[int_off];
                            EXT: begin
                                mem_addr_o  <= cpu_addr_i[EXT_AW-1:0];
                                mem_wdata_o <= cpu_wdata_i;
                                mem_oe_n_o  <= ~bus_rd;
                                mem_we_n_o  <= ~bus_wr;
                                if (EXT_WAIT == 0) begin
                                    state <= DONE;
                                end else begin
                                    cpu_clken_o <= 1'b0;
                                    wait_cnt    <= 4'(EXT_WAIT - 1);
                                    state       <= WAIT;
                                end
                            end
                            default: if (bus_rd) cpu_rdata_o <= UNMAPPED_RDATA;
                        endcase
                    end
                end
                WAIT: begin
                    // Release the stall one cycle early so the CPU advances as DONE samples data.
                    if (wait_cnt == 4'd0) begin
                        cpu_clken_o <= 1'b1;
                        state       <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (!mem_oe_n_o) cpu_rdata_o <= mem_rdata_i;
                    mem_oe_n_o <= 1'b1;
                    mem_we_n_o <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign wp_err_o    = WP_EN & wp_err;
    assign dbg_state_o = state;

endmodule

// File: tb/tb_cc3_sys_ctrl.sv
// Directed bench for cc3_sys_ctrl: one instance with EXT_WAIT=2, one with EXT_WAIT=0.
module tb_cc3_sys_ctrl;

    logic        clk32_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        cpu_oe_i = 1'b0, cpu_we_i = 1'b0;
    logic [15:0] cpu_addr_i = 16'h0000;
    logic [7:0]  cpu_wdata_i = 8'h00, mem_rdata_i = 8'h00;
    logic        nmi_n_i = 1'b1, irq_n_i = 1'b1, firq_n_i = 1'b1;

    logic        cpu_reset_n_o, cpu_clken_o, cpu_nmi_n_o, cpu_irq_n_o, cpu_firq_n_o;
    logic [7:0]  cpu_rdata_o, mem_wdata_o;
    logic [14:0] mem_addr_o;
    logic        mem_oe_n_o, mem_we_n_o, wp_err_o;
    logic [1:0]  dbg_state_o;

    logic        w0_cpu_reset_n_o, w0_cpu_clken_o, w0_cpu_nmi_n_o, w0_cpu_irq_n_o, w0_cpu_firq_n_o;
    logic [7:0]  w0_cpu_rdata_o, w0_mem_wdata_o;
    logic [14:0] w0_mem_addr_o;
    logic        w0_mem_oe_n_o, w0_mem_we_n_o, w0_wp_err_o;
    logic [1:0]  w0_dbg_state_o;

    int checks = 0;
    int errors = 0;

    always #5 clk32_i = ~clk32_i;

    cc3_sys_ctrl #(.EXT_WAIT(2)) u_dut (
        .clk32_i(clk32_i), .reset_n_i(reset_n_i), .cpu_reset_n_o(cpu_reset_n_o), .cpu_clken_o(cpu_clken_o),
        .cpu_oe_i(cpu_oe_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
        .cpu_rdata_o(cpu_rdata_o), .nmi_n_i(nmi_n_i), .irq_n_i(irq_n_i), .firq_n_i(firq_n_i),
        .cpu_nmi_n_o(cpu_nmi_n_o), .cpu_irq_n_o(cpu_irq_n_o), .cpu_firq_n_o(cpu_firq_n_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .mem_oe_n_o(mem_oe_n_o), .mem_we_n_o(mem_we_n_o), .wp_err_o(wp_err_o), .dbg_state_o(dbg_state_o)
    );

    cc3_sys_ctrl #(.EXT_WAIT(0)) u_dut0 (
        .clk32_i(clk32_i), .reset_n_i(reset_n_i), .cpu_reset_n_o(w0_cpu_reset_n_o), .cpu_clken_o(w0_cpu_clken_o),
        .cpu_oe_i(cpu_oe_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
        .cpu_rdata_o(w0_cpu_rdata_o), .nmi_n_i(nmi_n_i), .irq_n_i(irq_n_i), .firq_n_i(firq_n_i),
        .cpu_nmi_n_o(w0_cpu_nmi_n_o), .cpu_irq_n_o(w0_cpu_irq_n_o), .cpu_firq_n_o(w0_cpu_firq_n_o),
        .mem_addr_o(w0_mem_addr_o), .mem_wdata_o(w0_mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .mem_oe_n_o(w0_mem_oe_n_o), .mem_we_n_o(w0_mem_we_n_o), .wp_err_o(w0_wp_err_o), .dbg_state_o(w0_dbg_state_o)
    );

    task automatic tick();
        @(posedge clk32_i);
        #1;
    endtask

    task automatic test_reset();
        cpu_oe_i = 1'b1; cpu_addr_i = 16'h9000;
        nmi_n_i = 1'b0; irq_n_i = 1'b0; firq_n_i = 1'b0;
        reset_n_i = 1'b0;
        repeat (3) tick();
        checks++; if (cpu_reset_n_o !== 1'b0) begin errors++; $display("FAIL rst_cpu_reset: got %b exp 0", cpu_reset_n_o); end
        checks++; if (cpu_clken_o !== 1'b1) begin errors++; $display("FAIL rst_clken: got %b exp 1", cpu_clken_o); end
        checks++; if (cpu_rdata_o !== 8'h00) begin errors++; $display("FAIL rst_rdata: got %h exp 00", cpu_rdata_o); end
        checks++; if ({mem_oe_n_o, mem_we_n_o, wp_err_o} !== 3'b110) begin errors++; $display("FAIL rst_strobes: got %b exp 110", {mem_oe_n_o, mem_we_n_o, wp_err_o}); end
        checks++; if ({mem_addr_o, mem_wdata_o} !== 23'h0) begin errors++; $display("FAIL rst_mem_bus: got %h exp 0", {mem_addr_o, mem_wdata_o}); end
        checks++; if (dbg_state_o !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d exp 0", dbg_state_o); end
        reset_n_i = 1'b1;
        repeat (16) tick();
        checks++; if (cpu_reset_n_o !== 1'b0) begin errors++; $display("FAIL rst_early_release: got %b exp 0", cpu_reset_n_o); end
        checks++; if ({cpu_nmi_n_o, cpu_irq_n_o, cpu_firq_n_o} !== 3'b111) begin errors++; $display("FAIL rst_int_forced: got %b exp 111", {cpu_nmi_n_o, cpu_irq_n_o, cpu_firq_n_o}); end
        checks++; if (cpu_rdata_o !== 8'h00) begin errors++; $display("FAIL rst_oe_ignored: got %h exp 00", cpu_rdata_o); end
        tick();
        cpu_oe_i = 1'b0;
        checks++; if (cpu_reset_n_o !== 1'b1) begin errors++; $display("FAIL rst_release_17: got %b exp 1", cpu_reset_n_o); end
        checks++; if (w0_cpu_reset_n_o !== 1'b1) begin errors++; $display("FAIL rst_release_17_w0: got %b exp 1", w0_cpu_reset_n_o); end
        checks++; if ({cpu_nmi_n_o, cpu_irq_n_o, cpu_firq_n_o} !== 3'b000) begin errors++; $display("FAIL rst_int_pass: got %b exp 000", {cpu_nmi_n_o, cpu_irq_n_o, cpu_firq_n_o}); end
    endtask

    task automatic test_interrupts();
        nmi_n_i = 1'b1; irq_n_i = 1'b1; firq_n_i = 1'b1;
        tick();
        checks++; if ({cpu_nmi_n_o, cpu_irq_n_o, cpu_firq_n_o} !== 3'b000) begin errors++; $display("FAIL int_sync_1: got %b exp 000", {cpu_nmi_n_o, cpu_irq_n_o, cpu_firq_n_o}); end
        tick();
        checks++; if ({cpu_nmi_n_o, cpu_irq_n_o, cpu_firq_n_o} !== 3'b111) begin errors++; $display("FAIL int_sync_2: got %b exp 111", {cpu_nmi_n_o, cpu_irq_n_o, cpu_firq_n_o}); end
        irq_n_i = 1'b0;
        repeat (2) tick();
        checks++; if ({cpu_nmi_n_o, cpu_irq_n_o, cpu_firq_n_o} !== 3'b101) begin errors++; $display("FAIL int_irq_only: got %b exp 101", {cpu_nmi_n_o, cpu_irq_n_o, cpu_firq_n_o}); end
        irq_n_i = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_internal();
        cpu_we_i = 1'b1; cpu_addr_i = 16'hF810; cpu_wdata_i = 8'hA5;
        tick();
        checks++; if (cpu_clken_o !== 1'b1) begin errors++; $display("FAIL int_wr_clken: got %b exp 1", cpu_clken_o); end
        cpu_addr_i = 16'hF800; cpu_wdata_i = 8'h77;
        tick();
        cpu_we_i = 1'b0; cpu_oe_i = 1'b1; cpu_addr_i = 16'hF810;
        tick();
        checks++; if (cpu_rdata_o !== 8'hA5) begin errors++; $display("FAIL int_rd_f810: got %h exp a5", cpu_rdata_o); end
        checks++; if (cpu_clken_o !== 1'b1) begin errors++; $display("FAIL int_rd_clken: got %b exp 1", cpu_clken_o); end
        cpu_addr_i = 16'hF800;
        tick();
        checks++; if (cpu_rdata_o !== 8'h77) begin errors++; $display("FAIL int_rd_base: got %h exp 77", cpu_rdata_o); end
        cpu_addr_i = 16'hF7FF;
        tick();
        cpu_oe_i = 1'b0;
        checks++; if (cpu_rdata_o !== 8'hFF) begin errors++; $display("FAIL below_int_base: got %h exp ff", cpu_rdata_o); end
    endtask

    task automatic test_ext_read();
        int n_oe = 0;
        int n_ck = 0;
        mem_rdata_i = 8'h3C; cpu_oe_i = 1'b1; cpu_addr_i = 16'h1234;
        tick();
        cpu_oe_i = 1'b0;
        checks++; if (mem_addr_o !== 15'h1234) begin errors++; $display("FAIL ext_rd_addr: got %h exp 1234", mem_addr_o); end
        checks++; if (dbg_state_o !== 2'd1) begin errors++; $display("FAIL ext_rd_state: got %0d exp 1", dbg_state_o); end
        for (int i = 0; i < 8; i++) begin
            if (mem_oe_n_o === 1'b0) n_oe++;
            if (cpu_clken_o === 1'b0) n_ck++;
            tick();
        end
        checks++; if (n_oe !== 3) begin errors++; $display("FAIL ext_rd_oe_len: got %0d exp 3", n_oe); end
        checks++; if (n_ck !== 2) begin errors++; $display("FAIL ext_rd_stall_len: got %0d exp 2", n_ck); end
        checks++; if (cpu_rdata_o !== 8'h3C) begin errors++; $display("FAIL ext_rd_data: got %h exp 3c", cpu_rdata_o); end
        checks++; if (mem_we_n_o !== 1'b1) begin errors++; $display("FAIL ext_rd_no_we: got %b exp 1", mem_we_n_o); end
    endtask

    task automatic test_ext_nowait_unmapped();
        int n_we = 0;
        int n_ck = 0;
        cpu_we_i = 1'b1; cpu_addr_i = 16'h0002; cpu_wdata_i = 8'h5A;
        tick();
        cpu_we_i = 1'b0;
        checks++; if ({w0_mem_addr_o, w0_mem_wdata_o} !== {15'h0002, 8'h5A}) begin errors++; $display("FAIL ext0_wr_bus: got %h exp 00025a", {w0_mem_addr_o, w0_mem_wdata_o}); end
        checks++; if (w0_dbg_state_o !== 2'd2) begin errors++; $display("FAIL ext0_wr_state: got %0d exp 2", w0_dbg_state_o); end
        for (int i = 0; i < 6; i++) begin
            if (w0_mem_we_n_o === 1'b0) n_we++;
            if (w0_cpu_clken_o === 1'b0) n_ck++;
            tick();
        end
        checks++; if (n_we !== 1) begin errors++; $display("FAIL ext0_we_len: got %0d exp 1", n_we); end
        checks++; if (n_ck !== 0) begin errors++; $display("FAIL ext0_stall_len: got %0d exp 0", n_ck); end
        cpu_oe_i = 1'b1; cpu_addr_i = 16'h9000;
        tick();
        cpu_oe_i = 1'b0;
        checks++; if (cpu_rdata_o !== 8'hFF) begin errors++; $display("FAIL unmapped_rd: got %h exp ff", cpu_rdata_o); end
        checks++; if (w0_cpu_rdata_o !== 8'hFF) begin errors++; $display("FAIL unmapped_rd_w0: got %h exp ff", w0_cpu_rdata_o); end
        checks++; if ({cpu_clken_o, mem_oe_n_o} !== 2'b11) begin errors++; $display("FAIL unmapped_no_stall: got %b exp 11", {cpu_clken_o, mem_oe_n_o}); end
    endtask

    task automatic test_write_protect();
        int n_wp = 0;
        logic [7:0] exp_fc00;
`ifdef CC3_WRITE_PROTECT_EN
        int exp_wp = 1;
        exp_fc00 = 8'h00;
`else
        int exp_wp = 0;
        exp_fc00 = 8'h11;
`endif
        cpu_we_i = 1'b1; cpu_addr_i = 16'hFC00; cpu_wdata_i = 8'h11;
        tick();
        cpu_we_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (wp_err_o === 1'b1) n_wp++;
            tick();
        end
        checks++; if (n_wp !== exp_wp) begin errors++; $display("FAIL wp_pulses: got %0d exp %0d", n_wp, exp_wp); end
        cpu_oe_i = 1'b1;
        tick();
        cpu_oe_i = 1'b0;
        checks++; if (cpu_rdata_o !== exp_fc00) begin errors++; $display("FAIL wp_readback: got %h exp %h", cpu_rdata_o, exp_fc00); end
        cpu_we_i = 1'b1; cpu_addr_i = 16'hFBFF; cpu_wdata_i = 8'h22;
        tick();
        cpu_we_i = 1'b0;
        checks++; if (wp_err_o !== 1'b0) begin errors++; $display("FAIL wp_below_limit_err: got %b exp 0", wp_err_o); end
        cpu_oe_i = 1'b1;
        tick();
        cpu_oe_i = 1'b0;
        checks++; if (cpu_rdata_o !== 8'h22) begin errors++; $display("FAIL wp_below_limit_rd: got %h exp 22", cpu_rdata_o); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        cpu_oe_i = 1'b1; cpu_addr_i = 16'h1234;
        tick();
        cpu_oe_i = 1'b0;
        checks++; if ({dbg_state_o, mem_oe_n_o} !== 3'b010) begin errors++; $display("FAIL mid_in_wait: got %b exp 010", {dbg_state_o, mem_oe_n_o}); end
        #1 reset_n_i = 1'b0;
        #1;
        checks++; if ({mem_oe_n_o, mem_we_n_o} !== 2'b11) begin errors++; $display("FAIL mid_strobes: got %b exp 11", {mem_oe_n_o, mem_we_n_o}); end
        checks++; if (cpu_reset_n_o !== 1'b0) begin errors++; $display("FAIL mid_cpu_reset: got %b exp 0", cpu_reset_n_o); end
        checks++; if ({dbg_state_o, cpu_clken_o} !== 3'b001) begin errors++; $display("FAIL mid_state: got %b exp 001", {dbg_state_o, cpu_clken_o}); end
        repeat (2) tick();
        reset_n_i = 1'b1;
        while (cpu_reset_n_o !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++; if (n !== 17) begin errors++; $display("FAIL mid_rerelease_cycles: got %0d exp 17", n); end
        checks++; if ({dbg_state_o, mem_oe_n_o, mem_we_n_o} !== 4'b0011) begin errors++; $display("FAIL mid_resume_idle: got %b exp 0011", {dbg_state_o, mem_oe_n_o, mem_we_n_o}); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        tick();
        test_reset();
        test_interrupts();
        test_internal();
        test_ext_read();
        test_ext_nowait_unmapped();
        test_write_protect();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
